// File: rtl/cdc_toggle_sender.sv
// ---------------------------------------------------------------------------
// cdc_toggle_sender
//
// Source-domain half of a two-phase (toggle) clock-domain-crossing handshake.
// Words arrive on a valid/ready stream and are held in a two-entry in-order
// buffer. Each word is launched by loading it into req_data_o and inverting
// req_toggle_o. The sender then waits until the far side answers by
// inverting ack_toggle_i. Only after that does it launch the next word.
//
// Parameters
//   DATA_WIDTH   width of the transferred words
//   SYNC_STAGES  synchronizer depth on ack_toggle_i (must be >= 2)
//
// Ports
//   clk_i         source-domain clock
//   rst_i         synchronous active-high reset
//   s_valid_i     upstream word valid
//   s_data_i      upstream word
//   s_ready_o     buffer can accept a word (held low during reset)
//   req_toggle_o  request level; every transition announces a new word
//   req_data_o    launched word, held stable until the ack is seen
//   ack_toggle_i  acknowledge level from the destination domain (async)
//   busy_o        a word is buffered or in flight
//   xfer_count_o  completed transfers, wraps at 16 bits
//   proto_err_o   sticky: an ack edge arrived with nothing in flight
// ---------------------------------------------------------------------------
module cdc_toggle_sender #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  req_toggle_o,
    output logic [DATA_WIDTH-1:0] req_data_o,
    input  logic                  ack_toggle_i,
    output logic                  busy_o,
    output logic [15:0]           xfer_count_o,
    output logic                  proto_err_o
);

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Two-entry buffer
    // -----------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] fifo_mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  push;
    logic                  pop;

    // -----------------------------------------------------------------------
    // Handshake state
    // -----------------------------------------------------------------------
    state_t                state_q;
    logic                  req_toggle_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic [15:0]           xfer_count_q;
    logic                  proto_err_q;

    // Acknowledge synchronizer: stage 0 captures the asynchronous level, the
    // extra flop past SYNC_STAGES holds the previous synchronized value so an
    // edge can be detected.
    logic [SYNC_STAGES:0]  ack_sync_q;
    logic                  ack_pulse;

    // Ready depends only on the registered occupancy (and reset), so there is
    // no combinational path from s_valid_i back to s_ready_o.
    assign s_ready_o = !rst_i && (count_q != 2'd2);
    assign push      = s_valid_i && s_ready_o;
    assign pop       = (state_q == ST_IDLE) && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;   // none, or push+pop with count 1
        endcase
    end

    // Storage has no reset: contents are only ever read behind the count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= s_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // -----------------------------------------------------------------------
    // Ack synchronizer chain
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_sync_q[0] <= 1'b0;
        end else begin
            ack_sync_q[0] <= ack_toggle_i;
        end
    end

    for (genvar gi = 1; gi <= SYNC_STAGES; gi++) begin : g_ack_sync
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ack_sync_q[gi] <= 1'b0;
            end else begin
                ack_sync_q[gi] <= ack_sync_q[gi-1];
            end
        end
    end

    // One-cycle pulse per acknowledge transition, either direction.
    assign ack_pulse = ack_sync_q[SYNC_STAGES] ^ ack_sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Launch / wait-for-ack FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            req_toggle_q <= 1'b0;
            req_data_q   <= '0;
            xfer_count_q <= 16'd0;
            proto_err_q  <= 1'b0;
        end else begin
            // An ack edge with nothing outstanding means the two halves have
            // lost step; flag it and otherwise ignore the edge.
            if (ack_pulse && (state_q == ST_IDLE)) begin
                proto_err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (count_q != 2'd0) begin
                        req_data_q   <= fifo_mem_q[rd_ptr_q];
                        req_toggle_q <= ~req_toggle_q;
                        state_q      <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_pulse) begin
                        xfer_count_q <= xfer_count_q + 16'd1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_toggle_o = req_toggle_q;
    assign req_data_o   = req_data_q;
    assign xfer_count_o = xfer_count_q;
    assign proto_err_o  = proto_err_q;
    assign busy_o       = (state_q == ST_WAIT_ACK) || (count_q != 2'd0);

endmodule

// File: tb/tb_cdc_toggle_sender.sv
// ---------------------------------------------------------------------------
// tb_cdc_toggle_sender
//
// Stimulus pushes words and records each one in exp_q. An independent
// monitor watches req_toggle_o and compares every launched word against the
// head of exp_q. A destination-side model answers each request after a
// random delay when auto_ack is set; directed tests drive ack by hand.
// ---------------------------------------------------------------------------
module tb_cdc_toggle_sender;

    localparam int DW = 8;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          s_valid_i;
    logic [DW-1:0] s_data_i;
    logic          s_ready_o;
    logic          req_toggle_o;
    logic [DW-1:0] req_data_o;
    logic          ack_toggle_i;
    logic          busy_o;
    logic [15:0]   xfer_count_o;
    logic          proto_err_o;

    logic          ack_auto;
    logic          ack_manual;
    bit            auto_ack;

    int            total;
    int            bad;
    int            launches;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    assign ack_toggle_i = ack_auto ^ ack_manual;

    cdc_toggle_sender #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .s_valid_i    (s_valid_i),
        .s_data_i     (s_data_i),
        .s_ready_o    (s_ready_o),
        .req_toggle_o (req_toggle_o),
        .req_data_o   (req_data_o),
        .ack_toggle_i (ack_toggle_i),
        .busy_o       (busy_o),
        .xfer_count_o (xfer_count_o),
        .proto_err_o  (proto_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------
    // Monitor: one line per launched word, compared against the scoreboard
    // -------------------------------------------------------------------
    initial begin
        logic          prev_t;
        logic [DW-1:0] prev_d;
        logic [DW-1:0] want;
        prev_t = 1'b0;
        prev_d = '0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                prev_t = 1'b0;
                prev_d = '0;
            end else if (req_toggle_o !== prev_t) begin
                prev_t = req_toggle_o;
                launches++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_launch: got data=0x%0h want=no launch", req_data_o);
                end else begin
                    want = exp_q.pop_front();
                    $display("launch %0d toggle=%0b data=0x%0h expected=0x%0h",
                             launches, req_toggle_o, req_data_o, want);
                    check("launch_data", 32'(req_data_o), 32'(want));
                end
                prev_d = req_data_o;
            end else if (req_data_o !== prev_d) begin
                total++;
                bad++;
                $display("FAIL data_changed_without_toggle: got=0x%0h want=0x%0h", req_data_o, prev_d);
                prev_d = req_data_o;
            end
        end
    end

    // -------------------------------------------------------------------
    // Destination model: toggles ack after a random delay per request
    // -------------------------------------------------------------------
    initial begin
        logic seen;
        seen     = 1'b0;
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_i) begin
                seen     = 1'b0;
                ack_auto = 1'b0;
            end else if (auto_ack && (req_toggle_o !== seen)) begin
                seen = req_toggle_o;
                repeat ($urandom_range(0, 4)) @(negedge clk);
                ack_auto = ~ack_auto;
            end else begin
                seen = req_toggle_o;
            end
        end
    end

    // -------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge)
    // -------------------------------------------------------------------
    task automatic check_reset_values(input string tag);
        check({tag, "_req_toggle"}, 32'(req_toggle_o), 32'h0);
        check({tag, "_req_data"},   32'(req_data_o),   32'h0);
        check({tag, "_xfer_count"}, 32'(xfer_count_o), 32'h0);
        check({tag, "_proto_err"},  32'(proto_err_o),  32'h0);
        check({tag, "_busy"},       32'(busy_o),       32'h0);
        check({tag, "_s_ready"},    32'(s_ready_o),    32'h0);
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        s_valid_i  = 1'b0;
        ack_manual = 1'b0;
        auto_ack   = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        check_reset_values("rst");
        rst_i = 1'b0;
        @(negedge clk);
        check("post_reset_s_ready", 32'(s_ready_o), 32'h1);
    endtask

    task automatic push(input logic [DW-1:0] d);
        int c;
        s_valid_i = 1'b1;
        s_data_i  = d;
        c = 0;
        while (!s_ready_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got s_ready=0 want=1 within 100 cycles");
        end else begin
            exp_q.push_back(d);
            $display("push data=0x%0h", d);
            @(negedge clk);
        end
        s_valid_i = 1'b0;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            push(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic wait_idle(input int limit);
        int c;
        c = 0;
        while (busy_o !== 1'b0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (c >= limit) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got busy=%0b want=0 within %0d cycles", busy_o, limit);
        end
    endtask

    // -------------------------------------------------------------------
    // Directed tests
    // -------------------------------------------------------------------
    initial begin
        int base;
        total      = 0;
        bad        = 0;
        launches   = 0;
        rst_i      = 1'b1;
        s_valid_i  = 1'b0;
        s_data_i   = '0;
        ack_manual = 1'b0;
        auto_ack   = 1'b0;

        // 1: single word, latency of launch and of ack-to-idle
        do_reset();
        push(8'hA5);
        check("t1_no_early_launch", 32'(req_toggle_o), 32'h0);
        @(negedge clk);
        check("t1_toggle", 32'(req_toggle_o), 32'h1);
        check("t1_data",   32'(req_data_o),   32'hA5);
        check("t1_busy",   32'(busy_o),       32'h1);
        ack_manual = ~ack_manual;
        repeat (SS) @(negedge clk);
        check("t1_still_waiting", 32'(busy_o),       32'h1);
        check("t1_count_before",  32'(xfer_count_o), 32'h0);
        @(negedge clk);
        check("t1_idle_busy",  32'(busy_o),       32'h0);
        check("t1_count",      32'(xfer_count_o), 32'h1);
        check("t1_no_err",     32'(proto_err_o),  32'h0);

        // 2: three words with no ack, then ack each in turn
        do_reset();
        base = launches;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        check("t2_full_ready",  32'(s_ready_o),       32'h0);
        check("t2_head_held",   32'(req_data_o),      32'h01);
        check("t2_one_launch",  32'(launches - base), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            ack_manual = ~ack_manual;
            repeat (SS + 1) @(negedge clk);
            check("t2_count", 32'(xfer_count_o), 32'(k));
            @(negedge clk);
        end
        check("t2_launches", 32'(launches - base), 32'h3);
        check("t2_busy",     32'(busy_o),          32'h0);

        // 3: ack edge while idle is a sticky protocol error
        do_reset();
        base = launches;
        ack_manual = ~ack_manual;
        repeat (SS + 2) @(negedge clk);
        check("t3_err_set",   32'(proto_err_o),     32'h1);
        check("t3_count",     32'(xfer_count_o),    32'h0);
        check("t3_busy",      32'(busy_o),          32'h0);
        check("t3_no_launch", 32'(launches - base), 32'h0);
        auto_ack = 1'b1;
        stream(5);
        wait_idle(200);
        check("t3_err_held", 32'(proto_err_o),  32'h1);
        check("t3_count5",   32'(xfer_count_o), 32'h5);
        do_reset();
        check("t3_err_cleared", 32'(proto_err_o), 32'h0);

        // 4: random words with valid held high and randomized ack delay
        auto_ack = 1'b1;
        stream(1000);
        wait_idle(200);
        check("t4_count", 32'(xfer_count_o), 32'd1000);
        check("t4_queue_empty", 32'(exp_q.size()), 32'h0);

        // 5: transfer counter wrap
        do_reset();
        auto_ack = 1'b1;
        stream(3);
        wait_idle(200);
        check("t5_count3", 32'(xfer_count_o), 32'h3);
        dut.xfer_count_q = 16'hFFFE;
        stream(1);
        wait_idle(200);
        check("t5_count_ffff", 32'(xfer_count_o), 32'hFFFF);
        stream(1);
        wait_idle(200);
        check("t5_count_wrap", 32'(xfer_count_o), 32'h0000);

        // 6: reset while waiting for ack with two words buffered
        do_reset();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("t6_full", 32'(s_ready_o), 32'h0);
        rst_i = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check_reset_values("t6");
        rst_i = 1'b0;
        @(negedge clk);
        check("t6_ready", 32'(s_ready_o), 32'h1);
        push(8'h3C);
        check("t6_toggle_before", 32'(req_toggle_o), 32'h0);
        @(negedge clk);
        check("t6_toggle_after", 32'(req_toggle_o), 32'h1);
        check("t6_data",         32'(req_data_o),   32'h3C);
        ack_manual = ~ack_manual;
        repeat (SS + 1) @(negedge clk);
        check("t6_count", 32'(xfer_count_o), 32'h1);
        check("t6_busy",  32'(busy_o),       32'h0);

        check("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
